// File: rtl/alu_if.sv
// Bus bundle between the datapath controller and the accumulator ALU.
interface alu_if;
   logic [4:0]  opcode;
   logic [15:0] operand;
   logic        read;
   logic        write;
   logic [15:0] accout;
   logic        flag;

   modport master (
      output opcode,
      output operand,
      output read,
      output write,
      input  accout,
      input  flag
   );

   modport slave (
      input  opcode,
      input  operand,
      input  read,
      input  write,
      output accout,
      output flag
   );
endinterface

// File: rtl/alu.sv
// 16-bit accumulator ALU: acc is loaded by write, modified by opcodes, and
// copied to the registered accout port on read. A single status flag holds
// carry/borrow/shift-out/zero/compare results.
module alu (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   localparam logic [4:0] op_add    = 5'b00001;
   localparam logic [4:0] op_sub    = 5'b00010;
   localparam logic [4:0] op_adc    = 5'b00011;
   localparam logic [4:0] op_sbb    = 5'b00100;
   localparam logic [4:0] op_and    = 5'b00101;
   localparam logic [4:0] op_or     = 5'b00110;
   localparam logic [4:0] op_xor    = 5'b00111;
   localparam logic [4:0] op_not    = 5'b01000;
   localparam logic [4:0] op_shl    = 5'b01001;
   localparam logic [4:0] op_shr    = 5'b01010;
   localparam logic [4:0] op_sar    = 5'b01011;
   localparam logic [4:0] op_rol    = 5'b01100;
   localparam logic [4:0] op_ror    = 5'b01101;
   localparam logic [4:0] op_inc    = 5'b01110;
   localparam logic [4:0] op_dec    = 5'b01111;
   localparam logic [4:0] op_cmpeq  = 5'b10000;
   localparam logic [4:0] op_cmpltu = 5'b10001;
   localparam logic [4:0] op_cmplts = 5'b10010;
   localparam logic [4:0] op_neg    = 5'b10011;

   logic [15:0] acc_q;
   logic [15:0] accout_q;
   logic        flag_q;

   logic [15:0] res;
   logic        res_flag;
   logic [16:0] sum;

   assign bus.accout = accout_q;
   assign bus.flag   = flag_q;

   // Next acc/flag for the selected opcode; NOP and reserved codes hold state.
   // Bit 16 of the 17-bit sum is carry for additions and borrow for subtractions.
   always_comb begin
      res      = acc_q;
      res_flag = flag_q;
      sum      = '0;
      case (bus.opcode)
         op_add: begin
            sum      = {1'b0, acc_q} + {1'b0, bus.operand};
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_sub: begin
            sum      = {1'b0, acc_q} - {1'b0, bus.operand};
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_adc: begin
            sum      = {1'b0, acc_q} + {1'b0, bus.operand} + {16'b0, flag_q};
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_sbb: begin
            sum      = {1'b0, acc_q} - {1'b0, bus.operand} - {16'b0, flag_q};
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_and: begin
            res      = acc_q & bus.operand;
            res_flag = (res == 16'h0000);
         end
         op_or: begin
            res      = acc_q | bus.operand;
            res_flag = (res == 16'h0000);
         end
         op_xor: begin
            res      = acc_q ^ bus.operand;
            res_flag = (res == 16'h0000);
         end
         op_not: begin
            res      = ~acc_q;
            res_flag = (res == 16'h0000);
         end
         op_shl: begin
            res      = {acc_q[14:0], 1'b0};
            res_flag = acc_q[15];
         end
         op_shr: begin
            res      = {1'b0, acc_q[15:1]};
            res_flag = acc_q[0];
         end
         op_sar: begin
            res      = {acc_q[15], acc_q[15:1]};
            res_flag = acc_q[0];
         end
         op_rol: begin
            res      = {acc_q[14:0], acc_q[15]};
            res_flag = acc_q[15];
         end
         op_ror: begin
            res      = {acc_q[0], acc_q[15:1]};
            res_flag = acc_q[0];
         end
         op_inc: begin
            sum      = {1'b0, acc_q} + 17'd1;
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_dec: begin
            sum      = {1'b0, acc_q} - 17'd1;
            res      = sum[15:0];
            res_flag = sum[16];
         end
         op_cmpeq:  res_flag = (acc_q == bus.operand);
         op_cmpltu: res_flag = (acc_q < bus.operand);
         op_cmplts: res_flag = ($signed(acc_q) < $signed(bus.operand));
         op_neg: begin
            sum      = 17'd0 - {1'b0, acc_q};
            res      = sum[15:0];
            res_flag = (acc_q != 16'h0000);
         end
         default: ;
      endcase
   end

   // State update: write beats op execution; read copies the pre-edge acc and
   // suppresses execution when it appears alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= 16'h0000;
         accout_q <= 16'h0000;
         flag_q   <= 1'b0;
      end else begin
         if (bus.read) begin
            accout_q <= acc_q;
         end
         if (bus.write) begin
            acc_q <= bus.operand;
         end else if (!bus.read) begin
            acc_q  <= res;
            flag_q <= res_flag;
         end
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus updates an arithmetic reference model and
// queues the expected accout/flag for every read; a monitor pops and compares.
module tb_alu;

   logic clk;
   logic rst_n;
   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int m_acc  = 0;
   int m_flag = 0;
   logic [16:0] exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model written with plain integer arithmetic on 0..65535 values.
   function automatic void ref_exec(input int op, input int a, input int b, input int f,
                                    output int na, output int nf);
      int s;
      int sa;
      int sb;
      na = a;
      nf = f;
      case (op)
         1:  begin s = a + b;     na = s % 65536; nf = (s > 65535) ? 1 : 0; end
         2:  begin na = (a - b + 65536) % 65536; nf = (a < b) ? 1 : 0; end
         3:  begin s = a + b + f; na = s % 65536; nf = (s > 65535) ? 1 : 0; end
         4:  begin s = a - b - f; na = (s + 131072) % 65536; nf = (s < 0) ? 1 : 0; end
         5:  begin na = a & b; nf = (na == 0) ? 1 : 0; end
         6:  begin na = a | b; nf = (na == 0) ? 1 : 0; end
         7:  begin na = a ^ b; nf = (na == 0) ? 1 : 0; end
         8:  begin na = 65535 - a; nf = (na == 0) ? 1 : 0; end
         9:  begin na = (a * 2) % 65536; nf = (a >= 32768) ? 1 : 0; end
         10: begin na = a / 2; nf = a % 2; end
         11: begin na = a / 2 + ((a >= 32768) ? 32768 : 0); nf = a % 2; end
         12: begin na = (a * 2) % 65536 + a / 32768; nf = a / 32768; end
         13: begin na = a / 2 + (a % 2) * 32768; nf = a % 2; end
         14: begin na = (a + 1) % 65536; nf = (a == 65535) ? 1 : 0; end
         15: begin na = (a + 65535) % 65536; nf = (a == 0) ? 1 : 0; end
         16: nf = (a == b) ? 1 : 0;
         17: nf = (a < b) ? 1 : 0;
         18: begin
            sa = (a >= 32768) ? a - 65536 : a;
            sb = (b >= 32768) ? b - 65536 : b;
            nf = (sa < sb) ? 1 : 0;
         end
         19: begin na = (65536 - a) % 65536; nf = (a != 0) ? 1 : 0; end
         default: ;
      endcase
   endfunction

   // One bus cycle: drive at the falling edge, the DUT acts on the next rising edge.
   task automatic step(input bit r, input bit w, input logic [4:0] op, input logic [15:0] b);
      int na;
      int nf;
      @(negedge clk);
      bus.read    = r;
      bus.write   = w;
      bus.opcode  = op;
      bus.operand = b;
      if (r) exp_q.push_back({m_acc[15:0], m_flag[0]});
      if (w) begin
         m_acc = int'(b);
      end else if (!r) begin
         ref_exec(int'(op), m_acc, int'(b), m_flag, na, nf);
         m_acc  = na;
         m_flag = nf;
      end
   endtask

   // Reset dropped between clock edges; outputs must clear without a clock edge.
   task automatic mid_reset();
      @(negedge clk);
      bus.read  = 1'b0;
      bus.write = 1'b0;
      bus.opcode = 5'b00000;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_accout", bus.accout, 16'h0000);
      check("async_rst_flag", {15'b0, bus.flag}, 16'h0000);
      @(negedge clk);
      check("held_rst_accout", bus.accout, 16'h0000);
      rst_n  = 1'b1;
      m_acc  = 0;
      m_flag = 0;
   endtask

   // Monitor: after every rising edge that carried a read, compare against the queue.
   initial begin
      logic        rd;
      logic [16:0] e;
      forever begin
         @(posedge clk);
         rd = bus.read & rst_n;
         @(negedge clk);
         if (rd) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard_underflow: got read with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("accout", bus.accout, e[16:1]);
               check("flag", {15'b0, bus.flag}, {15'b0, e[0]});
            end
         end
      end
   end

   initial begin
      int r;
      bus.read    = 1'b0;
      bus.write   = 1'b0;
      bus.opcode  = 5'b00000;
      bus.operand = 16'h0000;
      rst_n       = 1'b1;

      // Power-on reset with no clock edge yet
      #2 rst_n = 1'b0;
      #1;
      check("por_accout", bus.accout, 16'h0000);
      check("por_flag", {15'b0, bus.flag}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 5'h00, 16'h0000);

      // SUB
      step(0, 1, 5'h00, 16'hFFFE);
      step(0, 0, 5'h02, 16'h0005);
      step(1, 0, 5'h00, 16'h0000);

      // INC wrap
      step(0, 1, 5'h00, 16'hFFFF);
      step(0, 0, 5'h0E, 16'h0000);
      step(1, 0, 5'h00, 16'h0000);

      // ADD carry then ADC
      step(0, 1, 5'h00, 16'h8000);
      step(0, 0, 5'h01, 16'h8000);
      step(0, 0, 5'h03, 16'h0001);
      step(1, 0, 5'h00, 16'h0000);

      // Compare and shift
      step(0, 1, 5'h00, 16'h1234);
      step(0, 0, 5'h10, 16'h1234);
      step(1, 0, 5'h00, 16'h0000);
      step(0, 0, 5'h12, 16'h8000);
      step(1, 0, 5'h00, 16'h0000);
      step(0, 0, 5'h0A, 16'h0000);
      step(1, 0, 5'h00, 16'h0000);

      // Read and write together
      step(0, 1, 5'h00, 16'h00AA);
      step(1, 1, 5'h00, 16'h5555);
      step(1, 0, 5'h00, 16'h0000);

      // Mid-operation reset, then a reserved opcode
      step(0, 1, 5'h00, 16'h7000);
      step(0, 0, 5'h01, 16'h9001);
      mid_reset();
      step(1, 0, 5'h00, 16'h0000);
      step(0, 0, 5'h1F, 16'hFFFF);
      step(1, 0, 5'h00, 16'h0000);

      // Randomised traffic, biased toward boundary operands
      for (int i = 0; i < 600; i++) begin
         logic [15:0] b;
         r = int'($urandom_range(0, 99));
         case ($urandom_range(0, 3))
            0:       b = 16'h0000;
            1:       b = 16'hFFFF;
            2:       b = 16'h8000;
            default: b = 16'($urandom());
         endcase
         if (r < 15)      step(0, 1, 5'($urandom()), b);
         else if (r < 40) step(1, 0, 5'($urandom()), b);
         else if (r < 45) step(1, 1, 5'($urandom()), b);
         else             step(0, 0, 5'($urandom_range(0, 31)), b);
      end
      step(1, 0, 5'h00, 16'h0000);
      step(0, 0, 5'h00, 16'h0000);
      @(negedge clk);
      @(negedge clk);

      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit accumulator-based ALU for the CPU datapath.
- Holds an internal accumulator (acc) that is loaded from the operand bus, modified by opcode-selected operations against the operand, and copied to a registered output port on request.
- Also maintains a single status flag for carry, borrow, shift-out, zero or compare results.

Parameters:
- None. Data width is fixed at 16 bits and opcode width at 5 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  5  operation select, sampled at the rising edge.
- operand  input  16  load data and second ALU operand.
- read  input  1  copy acc to accout at this edge.
- write  input  1  load acc from operand at this edge.
- accout  output  16  registered copy of acc; holds between reads.
- flag  output  1  registered status flag.

Behaviour:
- Reset: rst_n low immediately forces acc=0, accout=0, flag=0, independent of clk. State holds at those values while rst_n is low, and the first edge after release operates normally.
- Priority at each rising edge:
  - write=1: acc<=operand; flag unchanged; opcode ignored.
  - read=1: accout<=acc, using the value before this edge.
  - Neither asserted: execute the opcode, acc<=result.
  - read=1 and write=1 together: accout takes the old acc and acc loads operand.
  - read=1 alone: no operation executes.
- accout changes only on a read edge or reset. Latency from a write or op to visible accout is one read cycle.
- Opcode map (A=acc, B=operand; results truncated to 16 bits):
  - 00000 NOP: A and flag unchanged.
  - 00001 ADD: A+B; flag=carry out of bit 15.
  - 00010 SUB: A-B; flag=borrow, i.e. A<B unsigned.
  - 00011 ADC: A+B+flag; flag=carry.
  - 00100 SBB: A-B-flag; flag=borrow.
  - 00101 AND: A&B; flag=(result==0).
  - 00110 OR: A|B; flag=(result==0).
  - 00111 XOR: A^B; flag=(result==0).
  - 01000 NOT: ~A; flag=(result==0).
  - 01001 SHL: A<<1; flag=old A[15].
  - 01010 SHR (logical): A>>1; flag=old A[0].
  - 01011 SAR (arithmetic): A>>>1 with sign fill; flag=old A[0].
  - 01100 ROL by 1: flag=old A[15].
  - 01101 ROR by 1: flag=old A[0].
  - 01110 INC: A+1; flag=carry (1 only when A was FFFF).
  - 01111 DEC: A-1; flag=borrow (1 only when A was 0000).
  - 10000 CMPEQ: A unchanged; flag=(A==B).
  - 10001 CMPLTU: A unchanged; flag=(A<B) unsigned.
  - 10010 CMPLTS: A unchanged; flag=(A<B) two's complement.
  - 10011 NEG: 0-A; flag=(A!=0).
  - 10100-11111: reserved, behave as NOP.
- Operand-only ops (NOT, shifts, rotates, INC, DEC, NEG) ignore B.
- Inputs are synchronous to clk. No combinational path from any input to accout or flag.

Test Plan:
- Reset: assert rst_n=0 with no clock -> accout=0000 and flag=0 immediately. Release, then read -> accout=0000.
- SUB: write FFFE; next edge opcode 00010, operand 0005; next edge read=1 -> accout=FFF9, flag=0.
- INC wrap: write FFFF; next edge opcode 01110, operand 0000; read -> accout=0000, flag=1.
- ADD carry then ADC: write 8000; ADD 8000 -> acc 0000, flag=1; ADC 0001 -> read gives accout=0002, flag=0.
- Compare and shift:
  - Write 1234; CMPEQ 1234 -> flag=1, read gives accout=1234.
  - CMPLTS 8000 -> flag=0.
  - SHR -> read gives accout=091A, flag=0.
- Priority and mid-operation reset:
  - Acc=00AA; read=1 and write=1 with operand 5555 -> accout=00AA; next read -> accout=5555.
  - Drop rst_n between clock edges during an ADD sequence -> acc, accout and flag all 0 at once; a reserved opcode 11111 afterwards leaves acc=0.
